// File: rtl/bat_amateur_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bat_amateur_loader_if : host word stream, RAM control and load status   rev 1.0
// ---------------------------------------------------------------------------
interface bat_amateur_loader_if;
   logic        LOAD_REQ;
   logic        IN_VALID;
   logic [15:0] IN_DATA;
   logic        IN_LAST;
   logic        IN_READY;
   logic        HALT;
   logic        RAM_EN;
   logic        RAM_RW;
   logic [15:0] CHECKSUM;
   logic [15:0] WORD_COUNT;
   logic        ERROR;

   // master: host side that feeds the program image and watches status
   modport master (
      output LOAD_REQ, IN_VALID, IN_DATA, IN_LAST,
      input  IN_READY, HALT, RAM_EN, RAM_RW, CHECKSUM, WORD_COUNT, ERROR
   );

   modport slave (
      input  LOAD_REQ, IN_VALID, IN_DATA, IN_LAST,
      output IN_READY, HALT, RAM_EN, RAM_RW, CHECKSUM, WORD_COUNT, ERROR
   );
endinterface
`default_nettype wire

// File: rtl/bat_amateur_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bat_amateur_loader : holds the CPU in HALT and streams a program into RAM   rev 1.0
// ---------------------------------------------------------------------------
module bat_amateur_loader #(
   parameter int                     ADDRESS_WIDTH = 16,
   parameter logic [ADDRESS_WIDTH-1:0] MAX_ADDR    = '1
) (
   input  wire                      CLK,
   input  wire                      RESET,
   bat_amateur_loader_if.slave      bus,
   output wire [ADDRESS_WIDTH-1:0]  ADDRESS_BUS,
   output wire [15:0]               DATA_BUS
);

   // One extra bit so the pointer can sit at MAX_ADDR+1 without wrapping.
   localparam int PTR_W = ADDRESS_WIDTH + 1;

   typedef enum logic [1:0] {
      S_GET_ADDR = 2'd0,
      S_GET_DATA = 2'd1,
      S_WRITE    = 2'd2,
      S_RUN      = 2'd3
   } state_t;

   state_t                   state_q, state_d;
   logic [PTR_W-1:0]         ptr_q, ptr_d;
   logic                     last_q, last_d;
   logic                     halt_q, halt_d;
   logic                     ready_q, ready_d;
   logic                     ram_en_q, ram_en_d;
   logic                     ram_rw_q, ram_rw_d;
   logic                     drive_q, drive_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]              data_q, data_d;
   logic [15:0]              cs_q, cs_d;
   logic [15:0]              cnt_q, cnt_d;
   logic                     err_q, err_d;
   logic                     accept;
   logic                     ptr_in_range;

   assign accept       = bus.IN_VALID & ready_q;
   assign ptr_in_range = (ptr_q <= {1'b0, MAX_ADDR});

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= S_GET_ADDR;
         ptr_q    <= '0;
         last_q   <= 1'b0;
         halt_q   <= 1'b1;
         ready_q  <= 1'b0;
         ram_en_q <= 1'b0;
         ram_rw_q <= 1'b1;
         drive_q  <= 1'b1;
         addr_q   <= '0;
         data_q   <= '0;
         cs_q     <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         last_q   <= last_d;
         halt_q   <= halt_d;
         ready_q  <= ready_d;
         ram_en_q <= ram_en_d;
         ram_rw_q <= ram_rw_d;
         drive_q  <= drive_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         cs_q     <= cs_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Every output is computed for the state being entered, so it is registered
   // and lines up with state_q on the following cycle.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      last_d   = last_q;
      halt_d   = halt_q;
      ready_d  = ready_q;
      ram_en_d = 1'b0;
      ram_rw_d = 1'b1;
      drive_d  = drive_q;
      addr_d   = addr_q;
      data_d   = data_q;
      cs_d     = cs_q;
      cnt_d    = cnt_q;
      err_d    = err_q;

      case (state_q)
         S_GET_ADDR: begin
            ready_d = 1'b1;
            if (accept) begin
               ptr_d = PTR_W'(bus.IN_DATA);
               if (bus.IN_LAST) begin
                  state_d = S_RUN;
                  halt_d  = 1'b0;
                  drive_d = 1'b0;
                  ready_d = 1'b0;
               end else begin
                  state_d = S_GET_DATA;
               end
            end
         end

         S_GET_DATA: begin
            ready_d = 1'b1;
            if (accept) begin
               if (ptr_in_range) begin
                  state_d  = S_WRITE;
                  ready_d  = 1'b0;
                  ram_en_d = 1'b1;
                  ram_rw_d = 1'b0;
                  addr_d   = ptr_q[ADDRESS_WIDTH-1:0];
                  data_d   = bus.IN_DATA;
                  last_d   = bus.IN_LAST;
               end else begin
                  err_d = 1'b1;
                  if (bus.IN_LAST) begin
                     state_d = S_RUN;
                     halt_d  = 1'b0;
                     drive_d = 1'b0;
                     ready_d = 1'b0;
                  end
               end
            end
         end

         S_WRITE: begin
            cs_d  = cs_q + data_q;
            cnt_d = cnt_q + 16'd1;
            ptr_d = ptr_q + PTR_W'(1);
            if (last_q) begin
               state_d = S_RUN;
               halt_d  = 1'b0;
               drive_d = 1'b0;
               ready_d = 1'b0;
            end else begin
               state_d = S_GET_DATA;
               ready_d = 1'b1;
            end
         end

         S_RUN: begin
            ready_d = 1'b0;
            if (bus.LOAD_REQ) begin
               state_d = S_GET_ADDR;
               halt_d  = 1'b1;
               drive_d = 1'b1;
               ready_d = 1'b1;
               addr_d  = '0;
               data_d  = '0;
               cs_d    = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end

         default: begin
            state_d = S_GET_ADDR;
         end
      endcase
   end

   assign bus.IN_READY   = ready_q;
   assign bus.HALT       = halt_q;
   assign bus.RAM_EN     = ram_en_q;
   assign bus.RAM_RW     = ram_rw_q;
   assign bus.CHECKSUM   = cs_q;
   assign bus.WORD_COUNT = cnt_q;
   assign bus.ERROR      = err_q;

   // Buses float while the CPU owns them.
   assign ADDRESS_BUS = drive_q ? addr_q : {ADDRESS_WIDTH{1'bz}};
   assign DATA_BUS    = drive_q ? data_q : {16{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_bat_amateur_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bat_amateur_loader : scoreboard bench for the program loader   rev 1.0
// ---------------------------------------------------------------------------
module tb_bat_amateur_loader;

   localparam logic [15:0] MAX_A = 16'h00FF;

   logic        clk;
   logic        RESET;
   wire  [15:0] addr_bus;
   wire  [15:0] data_bus;

   bat_amateur_loader_if lif ();

   bat_amateur_loader #(
      .ADDRESS_WIDTH (16),
      .MAX_ADDR      (MAX_A)
   ) dut (
      .CLK         (clk),
      .RESET       (RESET),
      .bus         (lif.slave),
      .ADDRESS_BUS (addr_bus),
      .DATA_BUS    (data_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Scoreboard of expected RAM writes {address, data}, and a reference model.
   logic [31:0] sb[$];
   logic [15:0] prog[$];
   logic [16:0] m_ptr;
   logic [15:0] m_cs;
   logic [15:0] m_cnt;
   logic        m_err;

   task automatic model_clear(input logic [15:0] a);
      m_ptr = {1'b0, a};
      m_cs  = '0;
      m_cnt = '0;
      m_err = 1'b0;
   endtask

   task automatic model_word(input logic [15:0] w);
      if (m_ptr <= {1'b0, MAX_A}) begin
         sb.push_back({m_ptr[15:0], w});
         m_cs  = m_cs + w;
         m_cnt = m_cnt + 16'd1;
         m_ptr = m_ptr + 17'd1;
      end else begin
         m_err = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (lif.RAM_EN === 1'b1 && lif.RAM_RW === 1'b0) begin
         chk("write_expected", 32'(sb.size() != 0), 32'd1);
         chk("ready_in_write", 32'(lif.IN_READY), 32'd0);
         if (sb.size() != 0) begin
            logic [31:0] e;
            e = sb.pop_front();
            chk("write_addr", 32'(addr_bus), 32'(e[31:16]));
            chk("write_data", 32'(data_bus), 32'(e[15:0]));
         end
      end
   end

   // All tasks start and end just after a falling edge.
   task automatic send_word(input logic [15:0] d, input logic last, input int gapmax);
      int n;
      n = 0;
      repeat ($urandom_range(0, gapmax)) @(negedge clk);
      lif.IN_VALID = 1'b1;
      lif.IN_DATA  = d;
      lif.IN_LAST  = last;
      while (lif.IN_READY !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("in_ready_wait", 32'(lif.IN_READY), 32'd1);
      @(negedge clk);
      lif.IN_VALID = 1'b0;
      lif.IN_DATA  = 16'hDEAD;
      lif.IN_LAST  = 1'b1;
   endtask

   task automatic wait_run();
      int n;
      n = 0;
      while (lif.HALT !== 1'b0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("halt_release", 32'(lif.HALT), 32'd0);
   endtask

   task automatic run_load(input logic [15:0] a, input int gapmax);
      model_clear(a);
      send_word(a, prog.size() == 0, gapmax);
      for (int i = 0; i < prog.size(); i++) begin
         model_word(prog[i]);
         send_word(prog[i], i == prog.size() - 1, gapmax);
      end
      wait_run();
      chk("checksum", 32'(lif.CHECKSUM), 32'(m_cs));
      chk("word_count", 32'(lif.WORD_COUNT), 32'(m_cnt));
      chk("error", 32'(lif.ERROR), 32'(m_err));
      chk("run_ram_en", 32'(lif.RAM_EN), 32'd0);
      chk("run_ram_rw", 32'(lif.RAM_RW), 32'd1);
      chk("sb_drained", 32'(sb.size()), 32'd0);
   endtask

   task automatic load_req();
      lif.LOAD_REQ = 1'b1;
      @(negedge clk);
      lif.LOAD_REQ = 1'b0;
      chk("reload_halt", 32'(lif.HALT), 32'd1);
      chk("reload_count", 32'(lif.WORD_COUNT), 32'd0);
      chk("reload_cs", 32'(lif.CHECKSUM), 32'd0);
      chk("reload_err", 32'(lif.ERROR), 32'd0);
   endtask

   initial begin
      RESET        = 1'b1;
      lif.LOAD_REQ = 1'b0;
      lif.IN_VALID = 1'b0;
      lif.IN_DATA  = 16'h0000;
      lif.IN_LAST  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst_halt", 32'(lif.HALT), 32'd1);
      chk("rst_ram_en", 32'(lif.RAM_EN), 32'd0);
      chk("rst_ram_rw", 32'(lif.RAM_RW), 32'd1);
      chk("rst_ready", 32'(lif.IN_READY), 32'd0);
      chk("rst_cs", 32'(lif.CHECKSUM), 32'd0);
      chk("rst_count", 32'(lif.WORD_COUNT), 32'd0);
      chk("rst_err", 32'(lif.ERROR), 32'd0);
      RESET = 1'b0;

      // Three back-to-back words.
      prog = '{16'd5, 16'd0, 16'd1};
      run_load(16'h0010, 0);

      // Host words offered while running are neither accepted nor written.
      lif.IN_VALID = 1'b1;
      lif.IN_DATA  = 16'h1234;
      repeat (4) @(negedge clk);
      chk("run_ignores_valid", 32'(lif.IN_READY), 32'd0);
      lif.IN_VALID = 1'b0;
      chk("run_still_free", 32'(lif.HALT), 32'd0);

      // Fifteen words with random host gaps.
      load_req();
      prog.delete();
      prog.push_back(16'h0010);
      prog.push_back(16'h7F98);
      for (int i = 0; i < 12; i++) prog.push_back(16'($urandom));
      prog.push_back(16'h400E);
      run_load(16'h0000, 3);

      // Address-only stream: nothing written.
      load_req();
      prog.delete();
      run_load(16'h0005, 1);

      // Crossing MAX_ADDR: two writes, two dropped words, load still ends.
      load_req();
      prog = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
      run_load(16'h00FE, 1);

      // Reset during the second word's write cycle.
      load_req();
      model_clear(16'h0030);
      send_word(16'h0030, 1'b0, 0);
      model_word(16'h1111);
      send_word(16'h1111, 1'b0, 0);
      model_word(16'h2222);
      send_word(16'h2222, 1'b0, 0);
      RESET = 1'b1;
      @(negedge clk);
      chk("midrst_ram_en", 32'(lif.RAM_EN), 32'd0);
      chk("midrst_halt", 32'(lif.HALT), 32'd1);
      chk("midrst_count", 32'(lif.WORD_COUNT), 32'd0);
      chk("midrst_cs", 32'(lif.CHECKSUM), 32'd0);
      chk("midrst_ready", 32'(lif.IN_READY), 32'd0);
      RESET = 1'b0;
      prog = '{16'h0009, 16'h0003};
      run_load(16'h0040, 2);

      // Reload after a completed run clears earlier totals.
      load_req();
      prog = '{16'h0007};
      run_load(16'h0020, 0);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
